os_psum_collector: RTL and testbench

OS_PSUM_COLLECTOR -- requirements
Module: os_psum_collector

---
 rtl/os_pkg.sv | 17 +
 rtl/os_psum_deskew.sv | 44 ++++
 rtl/os_psum_collector.sv | 159 +++++++++++++++
 tb/tb_os_psum_collector.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_pkg.sv
// Shared types and constants for the output-stationary psum collector.
// Holds the FSM encoding and the default lane width with its saturation/ReLU bounds.
package os_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } os_state_e;

  localparam int PSUM_BW = 16;
  localparam logic [PSUM_BW-1:0] LANE_MAX  = 16'h7FFF;
  localparam logic [PSUM_BW-1:0] LANE_MIN  = 16'h8000;
  localparam logic [PSUM_BW-1:0] LANE_ZERO = 16'h0000;

endpackage

// File: rtl/os_psum_deskew.sv
// Per-column delay lines: column c is delayed (col-1-c) cycles so a skewed row exits aligned.
// Latency col-1-c cycles per column; no backpressure, data shifts every cycle.
module os_psum_deskew #(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         valid_i,
  input  logic [psum_bw*col-1:0] psum_i,
  output logic [col-1:0]         valid_o,
  output logic [psum_bw*col-1:0] psum_o
);

  for (genvar c = 0; c < col; c++) begin : g_col
    localparam int D = col - 1 - c;

    if (D == 0) begin : g_pass
      assign valid_o[c]                     = valid_i[c];
      assign psum_o[c*psum_bw +: psum_bw]   = psum_i[c*psum_bw +: psum_bw];
    end else begin : g_dly
      logic [D-1:0]       vld_sr;
      logic [psum_bw-1:0] dat_sr [D];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_sr <= '0;
          for (int i = 0; i < D; i++) dat_sr[i] <= '0;
        end else begin
          vld_sr[0] <= valid_i[c];
          dat_sr[0] <= psum_i[c*psum_bw +: psum_bw];
          for (int i = 1; i < D; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            dat_sr[i] <= dat_sr[i-1];
          end
        end
      end

      assign valid_o[c]                   = vld_sr[D-1];
      assign psum_o[c*psum_bw +: psum_bw] = dat_sr[D-1];
    end
  end

endmodule

// File: rtl/os_psum_collector.sv
// Collects deskewed output-stationary psum rows into SRAM, accumulating across passes.
// Write lands 1 cycle after row alignment (read issued in the alignment cycle); no backpressure.
module os_psum_collector
  import os_pkg::*;
#(
  parameter int psum_bw    = PSUM_BW,
  parameter int col        = 8,
  parameter int row        = 8,
  parameter int addr_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             npass_i,
  input  logic [addr_width-1:0]  base_addr_i,
  input  logic                   relu_en_i,
  input  logic [col-1:0]         array_valid_i,
  input  logic [psum_bw*col-1:0] array_psum_i,
  output logic                   sram_rd_en_o,
  output logic [addr_width-1:0]  sram_rd_addr_o,
  input  logic [psum_bw*col-1:0] sram_rdata_i,
  output logic                   sram_wr_en_o,
  output logic [addr_width-1:0]  sram_wr_addr_o,
  output logic [psum_bw*col-1:0] sram_wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int RCW = $clog2(row + 1);
  localparam int DW  = psum_bw * col;
  localparam logic [psum_bw-1:0] SAT_HI = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SAT_LO = {1'b1, {(psum_bw-1){1'b0}}};

  os_state_e state_q, state_d;

  logic [col-1:0]        al_vld;
  logic [DW-1:0]         al_psum;
  logic [3:0]            npass_q, pass_cnt_q;
  logic [addr_width-1:0] base_q, row_addr, wr_addr_q;
  logic                  relu_q, err_q;
  logic [RCW-1:0]        row_cnt_q;
  logic                  row_evt, last_row, final_pass, idle_like;
  logic                  wr_pend_q, acc_q, relu_now_q;
  logic [DW-1:0]         row_q, wdata;
  logic [psum_bw:0]      lane_sum;
  logic [psum_bw-1:0]    lane_res;

  os_psum_deskew #(.col(col), .psum_bw(psum_bw)) u_deskew (
    .clk     (clk),
    .reset   (reset),
    .valid_i (array_valid_i),
    .psum_i  (array_psum_i),
    .valid_o (al_vld),
    .psum_o  (al_psum)
  );

  assign final_pass = (pass_cnt_q == npass_q - 4'd1);
  assign row_evt    = (state_q == ST_DRAIN) && al_vld[col-1];
  assign last_row   = (row_cnt_q == RCW'(row - 1));
  assign row_addr   = base_q + addr_width'(row_cnt_q);
  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_DRAIN;
      ST_DRAIN: if (row_evt && last_row) state_d = ST_FLUSH;
      ST_FLUSH: if (!wr_pend_q) state_d = final_pass ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Job context is only captured from IDLE, so start_i is ignored while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      npass_q    <= 4'd1;
      pass_cnt_q <= '0;
      base_q     <= '0;
      relu_q     <= 1'b0;
      row_cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        npass_q    <= (npass_i == 4'd0) ? 4'd1 : npass_i;
        base_q     <= base_addr_i;
        relu_q     <= relu_en_i;
        pass_cnt_q <= '0;
        row_cnt_q  <= '0;
      end
      if (row_evt) row_cnt_q <= row_cnt_q + RCW'(1);
      if (state_q == ST_FLUSH && !wr_pend_q && !final_pass) begin
        pass_cnt_q <= pass_cnt_q + 4'd1;
        row_cnt_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      row_q      <= '0;
      acc_q      <= 1'b0;
      relu_now_q <= 1'b0;
    end else begin
      wr_pend_q <= row_evt;
      if (row_evt) begin
        wr_addr_q  <= row_addr;
        row_q      <= al_psum;
        acc_q      <= (pass_cnt_q != 4'd0);
        relu_now_q <= relu_q && final_pass;
      end
    end
  end

  // Stray valids, rows arriving outside DRAIN, and skew mismatches all latch err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if ((idle_like && |array_valid_i) ||
             (al_vld[col-1] && state_q != ST_DRAIN) ||
             (al_vld != {col{al_vld[0]}}))
      err_q <= 1'b1;
  end

  // Sign-extend both operands one bit; a carry into the extra bit that disagrees
  // with the lane MSB is an overflow and clamps toward the operands' sign.
  always_comb begin
    wdata    = '0;
    lane_sum = '0;
    lane_res = '0;
    for (int c = 0; c < col; c++) begin
      lane_sum = {row_q[c*psum_bw + psum_bw - 1], row_q[c*psum_bw +: psum_bw]} +
                 (acc_q ? {sram_rdata_i[c*psum_bw + psum_bw - 1],
                           sram_rdata_i[c*psum_bw +: psum_bw]} : '0);
      if (lane_sum[psum_bw] != lane_sum[psum_bw-1])
        lane_res = lane_sum[psum_bw] ? SAT_LO : SAT_HI;
      else
        lane_res = lane_sum[psum_bw-1:0];
      if (relu_now_q && lane_res[psum_bw-1]) lane_res = '0;
      wdata[c*psum_bw +: psum_bw] = lane_res;
    end
  end

  assign sram_rd_en_o   = row_evt && (pass_cnt_q != 4'd0);
  assign sram_rd_addr_o = sram_rd_en_o ? row_addr : '0;
  assign sram_wr_en_o   = wr_pend_q;
  assign sram_wr_addr_o = wr_pend_q ? wr_addr_q : '0;
  assign sram_wdata_o   = wr_pend_q ? wdata : '0;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_os_psum_collector.sv
// Directed bench for os_psum_collector: table of jobs plus reset/error corner sequences.
module tb_os_psum_collector;
  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int AW  = 8;
  localparam int DW  = PB * COL;
  localparam int NV  = 10;

  logic          clk = 1'b0;
  logic          reset, start_i, relu_en_i;
  logic [3:0]    npass_i;
  logic [AW-1:0] base_addr_i;
  logic [COL-1:0] array_valid_i;
  logic [DW-1:0] array_psum_i, sram_rdata_i, sram_wdata_o;
  logic          sram_rd_en_o, sram_wr_en_o, busy_o, done_o, err_o;
  logic [AW-1:0] sram_rd_addr_o, sram_wr_addr_o;

  always #5 clk = ~clk;

  os_psum_collector #(.psum_bw(PB), .col(COL), .row(ROW), .addr_width(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .npass_i(npass_i),
    .base_addr_i(base_addr_i), .relu_en_i(relu_en_i),
    .array_valid_i(array_valid_i), .array_psum_i(array_psum_i),
    .sram_rd_en_o(sram_rd_en_o), .sram_rd_addr_o(sram_rd_addr_o),
    .sram_rdata_i(sram_rdata_i), .sram_wr_en_o(sram_wr_en_o),
    .sram_wr_addr_o(sram_wr_addr_o), .sram_wdata_o(sram_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [3:0]    npass;
    logic [AW-1:0] base;
    logic          relu;
    logic [PB-1:0] pv0, pv1, pv2, step, inc;
    int            nwr, nrd;
    logic [PB-1:0] exp_p0, exp0, exp_step, exp_inc;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } acc_t;

  vec_t  vt [NV];
  vec_t  cv;
  acc_t  wq[$], rq[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    n_vec = 0, n_bad = 0;
  int    ws, rs, ds, np;
  int    t0 [4];
  string tag;

  logic [DW-1:0] mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_wr_en_o) mem[sram_wr_addr_o] <= sram_wdata_o;
    sram_rdata_i <= sram_rd_en_o ? mem[sram_rd_addr_o] : '0;
  end

  always @(negedge clk) begin
    if (sram_wr_en_o) wq.push_back('{sram_wr_addr_o, sram_wdata_o, cyc});
    if (sram_rd_en_o) rq.push_back('{sram_rd_addr_o, '0, cyc});
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PB-1:0] lane_val(input int p, input int k, input int c);
    logic [PB-1:0] b;
    b = (p == 0) ? cv.pv0 : (p == 1) ? cv.pv1 : cv.pv2;
    return b + PB'(k) * cv.step + PB'(c) * cv.inc;
  endfunction

  function automatic logic [DW-1:0] mkrow(input logic [PB-1:0] b, input logic [PB-1:0] inc);
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PB +: PB] = b + PB'(c) * inc;
    return r;
  endfunction

  // Column c carries row t-c; an extra start with a bogus job is pulsed mid-drain.
  task automatic drive_cycle(input int p, input int t, input int nrows, input int sr, input int sc);
    start_i     = (p == 0 && t == 3);
    npass_i     = start_i ? 4'd7 : cv.npass;
    base_addr_i = start_i ? 8'hAA : cv.base;
    for (int c = 0; c < COL; c++) begin
      int k;
      k = t - c;
      array_valid_i[c] = (k >= 0 && k < nrows) && !(k == sr && c == sc);
      array_psum_i[c*PB +: PB] = (k >= 0 && k < nrows) ? lane_val(p, k, c) : '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; start_i = 1'b0; array_valid_i = '0; array_psum_i = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_job(input int nrows, input int sr, input int sc);
    int w;
    np = (cv.npass == 4'd0) ? 1 : int'(cv.npass);
    ws = wq.size(); rs = rq.size(); ds = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b1; npass_i = cv.npass; base_addr_i = cv.base; relu_en_i = cv.relu;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int p = 0; p < np; p++) begin
      t0[p] = cyc;
      for (int t = 0; t < nrows + COL - 1; t++) begin
        if (t > 0) begin @(posedge clk); #1; end
        drive_cycle(p, t, nrows, sr, sc);
      end
      @(posedge clk); #1;
      array_valid_i = '0; array_psum_i = '0; start_i = 1'b0; base_addr_i = cv.base;
      repeat (3) @(posedge clk);
      #1;
    end
    w = 0;
    while (busy_o && w < 200) begin @(negedge clk); w++; end
    chk_i({tag, "_busy_end"}, int'(busy_o), 0);
  endtask

  task automatic check_job();
    int nw;
    nw = wq.size() - ws;
    chk_i({tag, "_wr_count"}, nw, cv.nwr);
    chk_i({tag, "_rd_count"}, rq.size() - rs, cv.nrd);
    chk_i({tag, "_done_pulses"}, done_cnt - ds, 1);
    chk_i({tag, "_err"}, int'(err_o), 0);
    if (nw > 0) chk_d({tag, "_pass0_row0"}, wq[ws].data, mkrow(cv.exp_p0, cv.inc));
    for (int k = 0; k < ROW; k++) begin
      int idx;
      idx = ws + (np - 1) * ROW + k;
      if (idx < wq.size()) begin
        chk_d($sformatf("%s_final_row%0d", tag, k), wq[idx].data,
              mkrow(cv.exp0 + PB'(k) * cv.exp_step, cv.exp_inc));
        chk_i($sformatf("%s_final_addr%0d", tag, k), int'(wq[idx].addr), (int'(cv.base) + k) % 256);
      end else begin
        chk_i($sformatf("%s_final_row%0d_missing", tag, k), idx, -1);
      end
      if (ws + k < wq.size())
        chk_i($sformatf("%s_p0_wr_cycle%0d", tag, k), wq[ws + k].cyc, t0[0] + k + COL);
    end
    for (int p = 1; p < np; p++) begin
      for (int k = 0; k < ROW; k++) begin
        int r, w;
        r = rs + (p - 1) * ROW + k;
        w = ws + p * ROW + k;
        if (r < rq.size()) begin
          chk_i($sformatf("%s_p%0d_rd_addr%0d", tag, p, k), int'(rq[r].addr), (int'(cv.base) + k) % 256);
          chk_i($sformatf("%s_p%0d_rd_cycle%0d", tag, p, k), rq[r].cyc, t0[p] + k + COL - 1);
        end
        if (w < wq.size())
          chk_i($sformatf("%s_p%0d_wr_cycle%0d", tag, p, k), wq[w].cyc, t0[p] + k + COL);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    reset = 1'b0; start_i = 1'b0; npass_i = '0; base_addr_i = '0; relu_en_i = 1'b0;
    array_valid_i = '0; array_psum_i = '0;

    //          npass  base   relu pv0      pv1      pv2    step   inc     nwr rd  exp_p0   exp0     estep  einc
    vt[0] = '{4'd1, 8'h10, 1'b0, 16'h0000, 16'h0000, 16'h0, 16'd1, 16'd16, 8,  0,  16'h0000, 16'h0000, 16'd1, 16'd16};
    vt[1] = '{4'd3, 8'h40, 1'b0, 16'h0005, 16'h0005, 16'h5, 16'd0, 16'd1,  24, 16, 16'h0005, 16'h000F, 16'd0, 16'd3};
    vt[2] = '{4'd2, 8'h20, 1'b0, 16'h7000, 16'h7000, 16'h0, 16'd0, 16'd0,  16, 8,  16'h7000, 16'h7FFF, 16'd0, 16'd0};
    vt[3] = '{4'd2, 8'h30, 1'b0, 16'h9000, 16'h9000, 16'h0, 16'd0, 16'd0,  16, 8,  16'h9000, 16'h8000, 16'd0, 16'd0};
    vt[4] = '{4'd2, 8'h50, 1'b1, 16'hFFFE, 16'hFFFF, 16'h0, 16'd0, 16'd0,  16, 8,  16'hFFFE, 16'h0000, 16'd0, 16'd0};
    vt[5] = '{4'd2, 8'h60, 1'b1, 16'hFFFD, 16'h000A, 16'h0, 16'd0, 16'd0,  16, 8,  16'hFFFD, 16'h0007, 16'd0, 16'd0};
    vt[6] = '{4'd1, 8'h70, 1'b1, 16'hFFFD, 16'h0000, 16'h0, 16'd0, 16'd0,  8,  0,  16'h0000, 16'h0000, 16'd0, 16'd0};
    vt[7] = '{4'd0, 8'h80, 1'b0, 16'h0009, 16'h0000, 16'h0, 16'd2, 16'd0,  8,  0,  16'h0009, 16'h0009, 16'd2, 16'd0};
    vt[8] = '{4'd1, 8'hFE, 1'b0, 16'h0001, 16'h0000, 16'h0, 16'd1, 16'd0,  8,  0,  16'h0001, 16'h0001, 16'd1, 16'd0};
    vt[9] = '{4'd2, 8'h90, 1'b0, 16'h8001, 16'hFFFF, 16'h0, 16'd0, 16'd0,  16, 8,  16'h8001, 16'h8000, 16'd0, 16'd0};

    repeat (2) @(negedge clk);
    chk_i("reset_busy", int'(busy_o), 0);
    chk_i("reset_enables", int'({sram_wr_en_o, sram_rd_en_o, done_o, err_o}), 0);
    chk_i("reset_addrs", int'({sram_wr_addr_o, sram_rd_addr_o}), 0);
    chk_d("reset_wdata", sram_wdata_o, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cv  = vt[i];
      tag = $sformatf("v%0d", i);
      run_job(ROW, -1, -1);
      check_job();
    end

    // Reset asserted in the middle of a drain abandons the job at once.
    cv = '{4'd2, 8'hC0, 1'b0, 16'h0003, 16'h0003, 16'h0, 16'd0, 16'd0, 16, 8, 16'h0003, 16'h0006, 16'd0, 16'd0};
    @(posedge clk); #1;
    start_i = 1'b1; npass_i = cv.npass; base_addr_i = cv.base; relu_en_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int t = 0; t < 10; t++) begin
      drive_cycle(0, t, ROW, -1, -1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk_i("midrst_busy", int'(busy_o), 0);
    chk_i("midrst_enables", int'({sram_wr_en_o, sram_rd_en_o, done_o, err_o}), 0);
    chk_i("midrst_addrs", int'({sram_wr_addr_o, sram_rd_addr_o}), 0);
    chk_d("midrst_wdata", sram_wdata_o, '0);
    start_i = 1'b0; array_valid_i = '0; array_psum_i = '0;
    repeat (2) @(posedge clk);
    #1;
    snap  = wq.size();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_i("release_no_write", wq.size() - snap, 0);
    chk_i("release_busy", int'(busy_o), 0);

    cv  = '{4'd2, 8'hC0, 1'b0, 16'h0002, 16'h0003, 16'h0, 16'd0, 16'd1, 16, 8, 16'h0002, 16'h0005, 16'd0, 16'd2};
    tag = "clean";
    run_job(ROW, -1, -1);
    check_job();

    // Valid while idle is flagged.
    @(posedge clk); #1;
    array_valid_i = 8'h01;
    @(posedge clk); #1;
    array_valid_i = '0;
    @(negedge clk);
    chk_i("idle_valid_err", int'(err_o), 1);
    chk_i("idle_valid_busy", int'(busy_o), 0);

    // A ninth row in a pass is dropped and flagged.
    do_reset();
    @(negedge clk);
    chk_i("err_cleared_by_reset", int'(err_o), 0);
    cv  = '{4'd1, 8'hD0, 1'b0, 16'h0004, 16'h0000, 16'h0, 16'd0, 16'd0, 8, 0, 16'h0004, 16'h0004, 16'd0, 16'd0};
    tag = "extra_row";
    run_job(ROW + 1, -1, -1);
    chk_i("extra_row_wr_count", wq.size() - ws, ROW);
    chk_i("extra_row_err", int'(err_o), 1);
    chk_i("extra_row_last_addr", int'(wq[wq.size() - 1].addr), 8'hD7);

    // One missing column valid is flagged but the row is still written.
    do_reset();
    cv  = '{4'd1, 8'hE0, 1'b0, 16'h0006, 16'h0000, 16'h0, 16'd0, 16'd0, 8, 0, 16'h0006, 16'h0006, 16'd0, 16'd0};
    tag = "skew_err";
    run_job(ROW, 3, 2);
    chk_i("skew_err_wr_count", wq.size() - ws, ROW);
    chk_i("skew_err_flag", int'(err_o), 1);
    if (ws + 3 < wq.size()) begin
      chk_i("skew_err_row3_addr", int'(wq[ws + 3].addr), 8'hE3);
      chk_d("skew_err_row3_data", wq[ws + 3].data, mkrow(16'h0006, 16'h0000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
